// File: rtl/ysyx_22051145_ifu_pkg.sv
// Shared definitions for the instruction fetch stage.
//   IFU_RESET_PC    : default fetch PC after reset
//   INST_NOP        : encoding of addi x0,x0,0
//   IFU_ENTRY_WIDTH : instruction buffer entry width, {[misalign,] pc[63:0], inst[31:0]}
//   ifu_state_e     : fetch FSM states
// Optional feature macro: YSYX_22051145_IFU_MISALIGN_CHK_EN (adds the misalign bit to each entry).
package ysyx_22051145_ifu_pkg;

    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

`ifdef YSYX_22051145_IFU_MISALIGN_CHK_EN
    localparam int unsigned IFU_ENTRY_WIDTH = 97;
`else
    localparam int unsigned IFU_ENTRY_WIDTH = 96;
`endif

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22051145_ifu_ibuf.sv
// Parametric synchronous FIFO with flush and a registered head entry.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : drop all entries; a push in the same cycle becomes the only entry
//   push, push_data     : write one entry (ignored when full unless a pop frees a slot)
//   pop                 : remove head entry (ignored when empty)
//   count               : number of stored entries
//   head_valid          : buffer not empty
//   head_data           : oldest entry
module ysyx_22051145_ifu_ibuf #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           head_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != CNT_FULL) || do_pop);
    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            if (push) begin
                mem[0] <= push_data;
                wr_ptr <= PTR_ONE;
                count  <= CNT_ONE;
            end else begin
                wr_ptr <= '0;
                count  <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (!do_push && do_pop) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/ysyx_22051145_ifu_stage.sv
// Instruction fetch stage: holds the fetch PC, issues one imem request at a time
// (req/gnt, then rvalid), buffers returned instructions and presents them to decode.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   jump_flag, jump_addr                : redirect from execute
//   imem_req, imem_addr                 : fetch request / word-aligned address
//   imem_gnt, imem_rvalid, imem_rdata   : grant, in-order response and data
//   if_valid, if_pc, if_inst, if_ready  : valid/ready hand-off to decode
//   if_misalign                         : only with YSYX_22051145_IFU_MISALIGN_CHK_EN; marks a
//                                         misaligned redirect target entry (NOP payload)
module ysyx_22051145_ifu_stage
    import ysyx_22051145_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = IFU_RESET_PC,
    parameter int unsigned IBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_flag,
    input  logic [63:0] jump_addr,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst,
`ifdef YSYX_22051145_IFU_MISALIGN_CHK_EN
    output logic        if_misalign,
`endif
    input  logic        if_ready
);

    localparam int unsigned CW = $clog2(IBUF_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);

    ifu_state_e state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic [63:0] stored_pc, stored_nxt;
    logic        drop, drop_nxt;
    logic        run;
    logic        halt;
    logic        handshake;
    logic [63:0] target;
    logic        push;
    logic [IFU_ENTRY_WIDTH-1:0] push_data;
    logic [IFU_ENTRY_WIDTH-1:0] head_data;
    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;

    // Outstanding request counts against buffer space so every granted response fits.
    assign occupancy = count + ((state == ST_WAIT) ? CW'(1) : '0);
    // run holds req low while in reset and until the first edge after release.
    assign imem_req  = run && (state == ST_REQ) && !halt && (occupancy < DEPTH_C);
    assign imem_addr = pc;
    assign handshake = imem_req && imem_gnt;

`ifdef YSYX_22051145_IFU_MISALIGN_CHK_EN
    logic misalign_jump;
    logic halt_nxt;
    assign target        = jump_addr;
    assign misalign_jump = jump_flag && (jump_addr[1:0] != 2'b00);
    assign halt_nxt      = jump_flag ? misalign_jump : halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halt <= 1'b0;
        else        halt <= halt_nxt;
    end
`else
    assign target = jump_addr & ~64'd3;
    assign halt   = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        stored_nxt = stored_pc;
        drop_nxt   = drop;
        push       = 1'b0;
`ifdef YSYX_22051145_IFU_MISALIGN_CHK_EN
        push_data  = {1'b0, stored_pc, imem_rdata};
`else
        push_data  = {stored_pc, imem_rdata};
`endif
        case (state)
            ST_REQ: begin
                if (handshake) begin
                    stored_nxt = pc;
                    pc_nxt     = pc + 64'd4;
                    state_nxt  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    push      = !drop;
                    drop_nxt  = 1'b0;
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_REQ;
        endcase
        // Redirect overrides the grant's pc+4 and suppresses the normal push; a request
        // left in flight (still waiting, or granted this cycle) must have its response dropped.
        if (jump_flag) begin
            pc_nxt = target;
            push   = 1'b0;
            if (((state == ST_WAIT) && !imem_rvalid) || handshake) begin
                drop_nxt = 1'b1;
            end
`ifdef YSYX_22051145_IFU_MISALIGN_CHK_EN
            if (misalign_jump) begin
                push      = 1'b1;
                push_data = {1'b1, jump_addr, INST_NOP};
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_REQ;
            pc        <= RESET_PC;
            stored_pc <= '0;
            drop      <= 1'b0;
            run       <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            stored_pc <= stored_nxt;
            drop      <= drop_nxt;
            run       <= 1'b1;
        end
    end

    ysyx_22051145_ifu_ibuf #(
        .WIDTH (IFU_ENTRY_WIDTH),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (jump_flag),
        .push       (push),
        .push_data  (push_data),
        .pop        (if_valid && if_ready),
        .count      (count),
        .head_valid (if_valid),
        .head_data  (head_data)
    );

    assign if_pc   = head_data[95:32];
    assign if_inst = head_data[31:0];
`ifdef YSYX_22051145_IFU_MISALIGN_CHK_EN
    assign if_misalign = head_data[96];
`endif

    assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid |-> (state == ST_WAIT));
`ifndef YSYX_22051145_IFU_MISALIGN_CHK_EN
    assert property (@(posedge clk) disable iff (!rst_n) imem_req |-> (imem_addr[1:0] == 2'b00));
`endif

endmodule

// File: tb/tb_ysyx_22051145_ifu_stage.sv
// Directed self-checking bench for ysyx_22051145_ifu_stage (IBUF_DEPTH=2).
module tb_ysyx_22051145_ifu_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump_flag;
    logic [63:0] jump_addr;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
`ifdef YSYX_22051145_IFU_MISALIGN_CHK_EN
    logic        if_misalign;
    localparam logic [63:0] TGT3 = 64'h8000_3000;
`else
    localparam logic [63:0] TGT3 = 64'h8000_3003;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_22051145_ifu_stage #(
        .RESET_PC   (64'h0000_0000_8000_0000),
        .IBUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .jump_flag   (jump_flag),
        .jump_addr   (jump_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
`ifdef YSYX_22051145_IFU_MISALIGN_CHK_EN
        .if_misalign (if_misalign),
`endif
        .if_ready    (if_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller guarantees FSM in REQ with room, gnt=1, if_ready=1.
    task automatic fetch_one(input logic [63:0] a, input logic [31:0] d);
        chk("fetch_req", 64'(imem_req), 64'd1);
        chk("fetch_addr", imem_addr, a);
        tick();
        chk("wait_no_req", 64'(imem_req), 64'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        tick();
        imem_rvalid = 1'b0;
        chk("fetch_valid", 64'(if_valid), 64'd1);
        chk("fetch_pc", if_pc, a);
        chk("fetch_inst", 64'(if_inst), 64'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; jump_flag = 1'b0; jump_addr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        #2;
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(if_valid), 64'd0);
        chk("rst_pc", if_pc, 64'd0);
        chk("rst_inst", 64'(if_inst), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk("first_req", 64'(imem_req), 64'd1);
        chk("first_addr", imem_addr, 64'h8000_0000);

        // Streaming fetch
        imem_gnt = 1'b1; if_ready = 1'b1;
        fetch_one(64'h8000_0000, 32'h1111_0000);
        fetch_one(64'h8000_0004, 32'h1111_0004);
        fetch_one(64'h8000_0008, 32'h1111_0008);

        // Back-pressure: buffer fills, requests stop
        if_ready = 1'b0;
        chk("bp_req", 64'(imem_req), 64'd1);
        chk("bp_addr", imem_addr, 64'h8000_000C);
        tick();
        chk("bp_wait", 64'(imem_req), 64'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_000C;
        tick();
        imem_rvalid = 1'b0;
        chk("full_no_req", 64'(imem_req), 64'd0);
        chk("full_head", if_pc, 64'h8000_0008);
        tick();
        chk("full_no_req2", 64'(imem_req), 64'd0);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        chk("pop_head_pc", if_pc, 64'h8000_000C);
        chk("pop_head_inst", 64'(if_inst), 64'h1111_000C);
        chk("pop_req", 64'(imem_req), 64'd1);
        chk("pop_addr", imem_addr, 64'h8000_0010);
        tick();
        chk("pop_wait", 64'(imem_req), 64'd0);

        // Redirect while waiting: stale response dropped
        jump_flag = 1'b1; jump_addr = 64'h8000_1000;
        tick();
        jump_flag = 1'b0;
        chk("jw_valid", 64'(if_valid), 64'd0);
        chk("jw_req", 64'(imem_req), 64'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("jw_drop_valid", 64'(if_valid), 64'd0);
        chk("jw_req2", 64'(imem_req), 64'd1);
        chk("jw_addr", imem_addr, 64'h8000_1000);
        tick();
        chk("jw_valid2", 64'(if_valid), 64'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h2222_1000;
        tick();
        imem_rvalid = 1'b0;
        chk("jw_new_valid", 64'(if_valid), 64'd1);
        chk("jw_new_pc", if_pc, 64'h8000_1000);
        chk("jw_new_inst", 64'(if_inst), 64'h2222_1000);

        // Redirect together with rvalid: no push, no drop
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h3333_0000;
        jump_flag = 1'b1; jump_addr = 64'h8000_2000;
        tick();
        imem_rvalid = 1'b0; jump_flag = 1'b0;
        chk("jr_valid", 64'(if_valid), 64'd0);
        chk("jr_req", 64'(imem_req), 64'd1);
        chk("jr_addr", imem_addr, 64'h8000_2000);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h3333_2000;
        tick();
        imem_rvalid = 1'b0;
        chk("jr_new_valid", 64'(if_valid), 64'd1);
        chk("jr_new_pc", if_pc, 64'h8000_2000);
        chk("jr_new_inst", 64'(if_inst), 64'h3333_2000);

        // Redirect in the grant cycle: granted response dropped, target low bits cleared
        chk("jg_addr_pre", imem_addr, 64'h8000_2004);
        jump_flag = 1'b1; jump_addr = TGT3;
        tick();
        jump_flag = 1'b0;
        chk("jg_valid", 64'(if_valid), 64'd0);
        chk("jg_req", 64'(imem_req), 64'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        chk("jg_drop_valid", 64'(if_valid), 64'd0);
        chk("jg_addr", imem_addr, 64'h8000_3000);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h4444_3000;
        tick();
        imem_rvalid = 1'b0;
        chk("jg_new_pc", if_pc, 64'h8000_3000);
        chk("jg_new_inst", 64'(if_inst), 64'h4444_3000);

        // PC wraps at 64 bits
        imem_gnt = 1'b0;
        jump_flag = 1'b1; jump_addr = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        jump_flag = 1'b0;
        chk("wrap_req", 64'(imem_req), 64'd1);
        chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_gnt = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h5555_FFFC;
        tick();
        imem_rvalid = 1'b0;
        chk("wrap_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_next_addr", imem_addr, 64'd0);

        // Asynchronous reset while waiting with an entry buffered
        tick();
        chk("ar_pre_valid", 64'(if_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(if_valid), 64'd0);
        chk("ar_req", 64'(imem_req), 64'd0);
        chk("ar_pc", if_pc, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("ar_rel_req", 64'(imem_req), 64'd1);
        chk("ar_rel_addr", imem_addr, 64'h8000_0000);

`ifdef YSYX_22051145_IFU_MISALIGN_CHK_EN
        imem_gnt = 1'b0;
        jump_flag = 1'b1; jump_addr = 64'h8000_0102;
        tick();
        jump_flag = 1'b0;
        chk("mis_valid", 64'(if_valid), 64'd1);
        chk("mis_pc", if_pc, 64'h8000_0102);
        chk("mis_inst", 64'(if_inst), 64'h0000_0013);
        chk("mis_flag", 64'(if_misalign), 64'd1);
        chk("mis_req", 64'(imem_req), 64'd0);
        tick();
        chk("mis_req_hold", 64'(imem_req), 64'd0);
        jump_flag = 1'b1; jump_addr = 64'h8000_0200;
        tick();
        jump_flag = 1'b0;
        chk("mis_resume_req", 64'(imem_req), 64'd1);
        chk("mis_resume_addr", imem_addr, 64'h8000_0200);
        chk("mis_resume_valid", 64'(if_valid), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
